flash_prog: RTL and testbench

FLASH_PROG -- requirements
Module: flash_prog

---
 rtl/flash_prog.sv | 232 +++++++++++++++++++++++
 tb/tb_flash_prog.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_prog.sv
// flash_prog: CPU register window driving JEDEC program/erase unlock sequences onto the ROM bus; FLASH_PROG_VERIFY_EN adds a read-back check.
// Latency: CMD write to done = 2 cycles per table write + poll cycles (+1 verify cycle) + 1 FIN cycle.
// Backpressure: none; register writes while busy are dropped, and a CMD write while busy flags overrun.
module flash_prog #(
   parameter logic [19:0] TIMEOUT  = 20'hFFFFF,
   parameter logic [4:0]  REG_BASE = 5'b11000
) (
   input  logic        phi2,
   input  logic        rst,
   input  logic        cctl_n,
   input  logic        r_w,
   input  logic [7:0]  cart_a,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        rdata_oe,
   output logic        bus_req,
   output logic [18:0] rom_a,
   output logic [7:0]  rom_dout,
   output logic        rom_dout_oe,
   input  logic [7:0]  rom_din,
   output logic        rom_ce_n,
   output logic        rom_oe_n,
   output logic        rom_we_n,
   output logic        busy
);

`ifdef FLASH_PROG_VERIFY_EN
   typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, POLL_A, POLL_B, FIN, VERIFY} state_t;
`else
   typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, POLL_A, POLL_B, FIN} state_t;
`endif

   localparam logic [1:0] CMD_PROG = 2'd1;
   localparam logic [1:0] CMD_SECT = 2'd2;

   state_t      state, state_nxt;
   logic [2:0]  step, step_nxt, last_step;
   logic [18:0] addr_q;
   logic [7:0]  data_q;
   logic [1:0]  cmd_q, cmd_nxt;
   logic        done_q, error_q, overrun_q, busy_q;
   logic        dq6_q;
   logic [19:0] poll_cnt;
   logic        sel, cpu_wr, cmd_ok, in_poll, poll_hit, poll_tmo, ver_err;
   logic [2:0]  off;
   logic [26:0] entry;
   logic        ce_nxt, oe_nxt, we_nxt, doe_nxt;
   logic [18:0] a_nxt;
   logic [7:0]  d_nxt;

   assign sel      = !cctl_n && (cart_a[7:3] == REG_BASE);
   assign off      = cart_a[2:0];
   assign cpu_wr   = sel && !r_w;
   assign rdata_oe = sel && r_w && (off == 3'd5);
   assign rdata    = {4'b0000, overrun_q, error_q, done_q, busy_q};
   assign busy     = busy_q;

   assign cmd_ok    = cpu_wr && (off == 3'd4) && !busy_q &&
                      (wdata == 8'h01 || wdata == 8'h02 || wdata == 8'h03);
   assign cmd_nxt   = cmd_ok ? wdata[1:0] : cmd_q;
   assign last_step = (cmd_q == CMD_PROG) ? 3'd3 : 3'd5;
   assign in_poll   = (state == POLL_A) || (state == POLL_B);
   assign poll_hit  = (state == POLL_B) && (rom_din[6] == dq6_q);

`ifndef FLASH_PROG_VERIFY_EN
   logic unused_din;
   assign unused_din = ^{rom_din[7], rom_din[5:0]};
`endif

   // Unlock tables: erase shares its five-write prefix between sector and chip.
   function automatic logic [26:0] tbl(input logic [1:0] cmd, input logic [2:0] stp,
                                       input logic [18:0] a, input logic [7:0] d);
      logic [26:0] e;
      e = {19'h05555, 8'hAA};
      if (cmd == CMD_PROG) begin
         case (stp)
            3'd0:    e = {19'h05555, 8'hAA};
            3'd1:    e = {19'h02AAA, 8'h55};
            3'd2:    e = {19'h05555, 8'hA0};
            default: e = {a, d};
         endcase
      end else begin
         case (stp)
            3'd0:    e = {19'h05555, 8'hAA};
            3'd1:    e = {19'h02AAA, 8'h55};
            3'd2:    e = {19'h05555, 8'h80};
            3'd3:    e = {19'h05555, 8'hAA};
            3'd4:    e = {19'h02AAA, 8'h55};
            default: e = (cmd == CMD_SECT) ? {a[18:12], 12'h000, 8'h30} : {19'h05555, 8'h10};
         endcase
      end
      return e;
   endfunction

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      poll_tmo  = 1'b0;
      ver_err   = 1'b0;
      case (state)
         IDLE: if (cmd_ok) begin
            state_nxt = WR_LO;
            step_nxt  = 3'd0;
         end
         WR_LO: state_nxt = WR_HI;
         WR_HI: if (step == last_step) begin
            state_nxt = POLL_A;
            step_nxt  = 3'd0;
         end else begin
            state_nxt = WR_LO;
            step_nxt  = step + 3'd1;
         end
         POLL_A, POLL_B: begin
            if (poll_hit) begin
`ifdef FLASH_PROG_VERIFY_EN
               state_nxt = (cmd_q == CMD_PROG) ? VERIFY : FIN;
`else
               state_nxt = FIN;
`endif
            end else if (poll_cnt + 20'd1 == TIMEOUT) begin
               poll_tmo  = 1'b1;
               state_nxt = FIN;
            end else begin
               state_nxt = POLL_B;
            end
         end
`ifdef FLASH_PROG_VERIFY_EN
         VERIFY: begin
            ver_err   = (rom_din != data_q);
            state_nxt = FIN;
         end
`endif
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ROM strobes are decoded from the next state so they flop alongside bus_req.
   always_comb begin
      ce_nxt  = 1'b1;
      oe_nxt  = 1'b1;
      we_nxt  = 1'b1;
      doe_nxt = 1'b0;
      a_nxt   = '0;
      d_nxt   = '0;
      entry   = tbl(cmd_nxt, step_nxt, addr_q, data_q);
      case (state_nxt)
         WR_LO: begin
            ce_nxt         = 1'b0;
            we_nxt         = 1'b0;
            doe_nxt        = 1'b1;
            {a_nxt, d_nxt} = entry;
         end
         WR_HI: begin
            ce_nxt         = 1'b0;
            doe_nxt        = 1'b1;
            {a_nxt, d_nxt} = entry;
         end
         POLL_A, POLL_B: begin
            ce_nxt = 1'b0;
            oe_nxt = 1'b0;
            a_nxt  = addr_q;
         end
`ifdef FLASH_PROG_VERIFY_EN
         VERIFY: begin
            ce_nxt = 1'b0;
            oe_nxt = 1'b0;
            a_nxt  = addr_q;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge phi2) begin
      if (rst) begin
         state       <= IDLE;
         step        <= 3'd0;
         addr_q      <= '0;
         data_q      <= '0;
         cmd_q       <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
         dq6_q       <= 1'b0;
         poll_cnt    <= '0;
         bus_req     <= 1'b0;
         rom_ce_n    <= 1'b1;
         rom_oe_n    <= 1'b1;
         rom_we_n    <= 1'b1;
         rom_dout_oe <= 1'b0;
         rom_a       <= '0;
         rom_dout    <= '0;
      end else begin
         state       <= state_nxt;
         step        <= step_nxt;
         bus_req     <= (state_nxt != IDLE);
         rom_ce_n    <= ce_nxt;
         rom_oe_n    <= oe_nxt;
         rom_we_n    <= we_nxt;
         rom_dout_oe <= doe_nxt;
         rom_a       <= a_nxt;
         rom_dout    <= d_nxt;
         if (in_poll) dq6_q <= rom_din[6];
         poll_cnt <= in_poll ? poll_cnt + 20'd1 : 20'd0;
         if (cpu_wr && !busy_q) begin
            case (off)
               3'd0:    addr_q[7:0]   <= wdata;
               3'd1:    addr_q[15:8]  <= wdata;
               3'd2:    addr_q[18:16] <= wdata[2:0];
               3'd3:    data_q        <= wdata;
               default: ;
            endcase
         end
         if (cmd_ok) begin
            cmd_q   <= wdata[1:0];
            done_q  <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
         end
         if (poll_tmo || ver_err) error_q <= 1'b1;
         if (state == FIN) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
         end
         if (cpu_wr && (off == 3'd4) && busy_q) overrun_q <= 1'b1;
         else if (rdata_oe)                     overrun_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_flash_prog.sv
// Bench for flash_prog: register-level stimulus, toggle-bit flash model, queue of expected ROM writes.
module tb_flash_prog;
   localparam logic [4:0] BASE = 5'b11000;
   localparam int TMO = 16;
`ifdef FLASH_PROG_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif

   logic        phi2 = 1'b0;
   logic        rst = 1'b1, cctl_n = 1'b1, r_w = 1'b1;
   logic [7:0]  cart_a = '0, wdata = '0, rom_din = '0;
   logic [7:0]  rdata, rom_dout;
   logic        rdata_oe, bus_req, rom_dout_oe, rom_ce_n, rom_oe_n, rom_we_n, busy;
   logic [18:0] rom_a;

   always #5 phi2 = ~phi2;

   flash_prog #(.TIMEOUT(20'd16), .REG_BASE(BASE)) dut (
      .phi2(phi2), .rst(rst), .cctl_n(cctl_n), .r_w(r_w), .cart_a(cart_a), .wdata(wdata),
      .rdata(rdata), .rdata_oe(rdata_oe), .bus_req(bus_req), .rom_a(rom_a),
      .rom_dout(rom_dout), .rom_dout_oe(rom_dout_oe), .rom_din(rom_din),
      .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n), .busy(busy));

   int checks = 0, errors = 0;
   logic [26:0] wr_q[$], exp_q[$];
   int n_reads = 0, n_viol = 0, toggles_left = 0, stable_cnt = 0;
   logic dq6 = 1'b0;
   logic [7:0] mem_byte = '0;

   // Flash model: DQ6 toggles on each read while busy, then two stable reads, then stored data.
   always @(negedge phi2) begin
      if (!rom_ce_n && !rom_we_n) wr_q.push_back({rom_a, rom_dout});
      if (!rom_ce_n && !rom_oe_n) begin
         n_reads++;
         if (toggles_left > 0) begin
            rom_din = {1'b0, dq6, 6'b0};
            dq6 = ~dq6;
            toggles_left--;
         end else if (stable_cnt < 2) begin
            rom_din = {1'b0, dq6, 6'b0};
            stable_cnt++;
         end else begin
            rom_din = mem_byte;
         end
      end
      if ((!rom_ce_n || !rom_oe_n || !rom_we_n || rom_dout_oe) && !bus_req) n_viol++;
      if (!rom_we_n && !rom_oe_n) n_viol++;
   end

   task automatic cpu_write(input logic [2:0] off, input logic [7:0] d);
      @(negedge phi2);
      cctl_n = 1'b0; r_w = 1'b0; cart_a = {BASE, off}; wdata = d;
      @(negedge phi2);
      cctl_n = 1'b1; r_w = 1'b1; cart_a = '0;
   endtask

   task automatic status_read(output logic [7:0] v, output logic oe);
      @(negedge phi2);
      cctl_n = 1'b0; r_w = 1'b1; cart_a = {BASE, 3'd5};
      #1;
      v = rdata; oe = rdata_oe;
      @(negedge phi2);
      cctl_n = 1'b1; cart_a = '0;
   endtask

   task automatic arm_model(input int tg, input logic [7:0] mem);
      toggles_left = tg; stable_cnt = 0; mem_byte = mem; dq6 = $urandom_range(0, 1);
   endtask

   task automatic start_seq(input logic [7:0] cmd, input logic [18:0] a, input logic [7:0] d);
      cpu_write(3'd0, a[7:0]);
      cpu_write(3'd1, a[15:8]);
      cpu_write(3'd2, {5'b0, a[18:16]});
      cpu_write(3'd3, d);
      wr_q.delete(); n_reads = 0; n_viol = 0;
      cpu_write(3'd4, cmd);
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 400) begin
         @(negedge phi2);
         cyc++;
      end
   endtask

   function automatic void build_exp(input logic [7:0] cmd, input logic [18:0] a, input logic [7:0] d);
      exp_q.delete();
      exp_q.push_back({19'h05555, 8'hAA});
      exp_q.push_back({19'h02AAA, 8'h55});
      if (cmd == 8'h01) begin
         exp_q.push_back({19'h05555, 8'hA0});
         exp_q.push_back({a, d});
      end else begin
         exp_q.push_back({19'h05555, 8'h80});
         exp_q.push_back({19'h05555, 8'hAA});
         exp_q.push_back({19'h02AAA, 8'h55});
         if (cmd == 8'h02) exp_q.push_back({a & 19'h7F000, 8'h30});
         else              exp_q.push_back({19'h05555, 8'h10});
      end
   endfunction

   task automatic test_reset;
      logic [7:0] v; logic oe;
      rst = 1'b1;
      repeat (3) @(negedge phi2);
      checks++;
      if ({bus_req, busy, rom_ce_n, rom_oe_n, rom_we_n, rom_dout_oe} !== 6'b001110) begin
         errors++; $display("FAIL reset_strobes got %b want 001110",
                            {bus_req, busy, rom_ce_n, rom_oe_n, rom_we_n, rom_dout_oe});
      end
      checks++;
      if ({rom_a, rom_dout} !== 27'd0) begin
         errors++; $display("FAIL reset_bus got %h/%h want 0/0", rom_a, rom_dout);
      end
      // CMD write in the same cycle as reset must be dropped
      cctl_n = 1'b0; r_w = 1'b0; cart_a = {BASE, 3'd4}; wdata = 8'h01;
      @(negedge phi2);
      cctl_n = 1'b1; r_w = 1'b1; cart_a = '0; rst = 1'b0;
      @(negedge phi2);
      checks++;
      if ({busy, bus_req} !== 2'b00) begin
         errors++; $display("FAIL reset_priority got busy=%b bus_req=%b want 0 0", busy, bus_req);
      end
      status_read(v, oe);
      checks++;
      if ({oe, v} !== {1'b1, 8'h00}) begin
         errors++; $display("FAIL reset_status got oe=%b %h want oe=1 00", oe, v);
      end
   endtask

   task automatic test_cmd_filter;
      cpu_write(3'd4, 8'h04);
      @(negedge phi2);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL bad_cmd got busy=%b want 0", busy); end
      @(negedge phi2);
      cctl_n = 1'b0; r_w = 1'b0; cart_a = {5'b10111, 3'd4}; wdata = 8'h01;
      @(negedge phi2);
      cctl_n = 1'b1; r_w = 1'b1; cart_a = '0;
      @(negedge phi2);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL bad_select got busy=%b want 0", busy); end
   endtask

   task automatic test_program;
      logic [18:0] a; logic [7:0] d, v; logic oe; int tg, cyc, p, ex; bit err;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin a = 19'h2C010; d = 8'h5A; tg = 3; end
         else begin a = 19'($urandom); d = 8'($urandom); tg = $urandom_range(0, 18); end
         p   = (tg + 2 > TMO) ? TMO : tg + 2;
         err = (tg + 2 > TMO);
         ex  = err ? 0 : VER;
         arm_model(tg, d);
         start_seq(8'h01, a, d);
         wait_idle(cyc);
         build_exp(8'h01, a, d);
         checks++;
         if (cyc !== 8 + p + ex + 1) begin
            errors++; $display("FAIL prog%0d_latency got %0d want %0d", i, cyc, 8 + p + ex + 1);
         end
         checks++;
         if (wr_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL prog%0d_nwrites got %0d want %0d", i, wr_q.size(), exp_q.size());
         end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
               checks++;
               if (wr_q[k] !== exp_q[k]) begin
                  errors++; $display("FAIL prog%0d_write%0d got %h want %h", i, k, wr_q[k], exp_q[k]);
               end
            end
         end
         checks++;
         if (n_reads !== p + ex) begin
            errors++; $display("FAIL prog%0d_reads got %0d want %0d", i, n_reads, p + ex);
         end
         status_read(v, oe);
         checks++;
         if (v !== {5'b0, err, 2'b10}) begin
            errors++; $display("FAIL prog%0d_status got %h want %h", i, v, {5'b0, err, 2'b10});
         end
         checks++;
         if ({bus_req, rom_ce_n, rom_oe_n, rom_we_n, rom_dout_oe, n_viol != 0} !== 6'b011100) begin
            errors++; $display("FAIL prog%0d_idle_bus got %b viol=%0d want 011100 viol=0", i,
                               {bus_req, rom_ce_n, rom_oe_n, rom_we_n, rom_dout_oe}, n_viol);
         end
      end
   endtask

   task automatic test_erase;
      logic [18:0] a; logic [7:0] d, v, cmd; logic oe; int tg, cyc, p; bit err;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin a = 19'h21234; d = 8'h00; tg = 2; cmd = 8'h02; end
         else begin
            a = 19'($urandom); d = 8'($urandom); tg = $urandom_range(0, 18);
            cmd = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h03;
         end
         p   = (tg + 2 > TMO) ? TMO : tg + 2;
         err = (tg + 2 > TMO);
         arm_model(tg, 8'hFF);
         start_seq(cmd, a, d);
         wait_idle(cyc);
         build_exp(cmd, a, d);
         checks++;
         if (cyc !== 12 + p + 1) begin
            errors++; $display("FAIL erase%0d_latency got %0d want %0d", i, cyc, 12 + p + 1);
         end
         checks++;
         if (wr_q.size() !== 6 || wr_q[5] !== exp_q[5] || wr_q[2] !== exp_q[2]) begin
            errors++; $display("FAIL erase%0d_writes got n=%0d last=%h want n=6 last=%h",
                               i, wr_q.size(), (wr_q.size() > 5) ? wr_q[5] : 27'h0, exp_q[5]);
         end
         checks++;
         if (n_reads !== p) begin
            errors++; $display("FAIL erase%0d_reads got %0d want %0d", i, n_reads, p);
         end
         status_read(v, oe);
         checks++;
         if (v !== {5'b0, err, 2'b10}) begin
            errors++; $display("FAIL erase%0d_status got %h want %h", i, v, {5'b0, err, 2'b10});
         end
      end
   endtask

   task automatic test_timeout;
      logic [7:0] v; logic oe; int cyc;
      arm_model(1000000, 8'h00);
      start_seq(8'h01, 19'h01234, 8'h77);
      wait_idle(cyc);
      checks++;
      if (cyc !== 8 + TMO + 1) begin
         errors++; $display("FAIL timeout_latency got %0d want %0d", cyc, 8 + TMO + 1);
      end
      checks++;
      if (n_reads !== TMO) begin
         errors++; $display("FAIL timeout_reads got %0d want %0d", n_reads, TMO);
      end
      n_reads = 0; wr_q.delete();
      repeat (5) @(negedge phi2);
      checks++;
      if (n_reads !== 0 || wr_q.size() !== 0 || bus_req !== 1'b0) begin
         errors++; $display("FAIL timeout_quiet got reads=%0d writes=%0d bus_req=%b want 0 0 0",
                            n_reads, wr_q.size(), bus_req);
      end
      status_read(v, oe);
      checks++;
      if (v !== 8'h06) begin errors++; $display("FAIL timeout_status got %h want 06", v); end
   endtask

   task automatic test_overrun;
      logic [18:0] a; logic [7:0] d, v1, v2; logic oe1, oe2; int cyc;
      a = 19'($urandom); d = 8'($urandom);
      arm_model(4, d);
      start_seq(8'h01, a, d);
      cpu_write(3'd4, 8'h03);
      cpu_write(3'd0, ~a[7:0]);
      cpu_write(3'd3, ~d);
      wait_idle(cyc);
      build_exp(8'h01, a, d);
      checks++;
      if (wr_q.size() !== 4 || wr_q[3] !== exp_q[3]) begin
         errors++; $display("FAIL overrun_writes got n=%0d last=%h want n=4 last=%h",
                            wr_q.size(), (wr_q.size() > 3) ? wr_q[3] : 27'h0, exp_q[3]);
      end
      status_read(v1, oe1);
      status_read(v2, oe2);
      checks++;
      if (v1 !== 8'h0A || oe1 !== 1'b1) begin
         errors++; $display("FAIL overrun_read1 got %h oe=%b want 0A oe=1", v1, oe1);
      end
      checks++;
      if (v2 !== 8'h02) begin errors++; $display("FAIL overrun_read2 got %h want 02", v2); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] v; logic oe;
      arm_model(6, 8'hFF);
      start_seq(8'h02, 19'($urandom), 8'($urandom));
      repeat (6) @(negedge phi2);
      checks++;
      if ({rom_we_n, rom_ce_n, rom_a, rom_dout} !== {2'b00, 19'h05555, 8'hAA}) begin
         errors++; $display("FAIL mid_step3 got we=%b ce=%b %h/%h want 0 0 05555/AA",
                            rom_we_n, rom_ce_n, rom_a, rom_dout);
      end
      rst = 1'b1;
      @(posedge phi2);
      #1;
      checks++;
      if ({rom_we_n, rom_ce_n, rom_oe_n, bus_req, busy} !== 5'b11100) begin
         errors++; $display("FAIL mid_reset got %b want 11100",
                            {rom_we_n, rom_ce_n, rom_oe_n, bus_req, busy});
      end
      @(negedge phi2);
      rst = 1'b0; wr_q.delete(); n_reads = 0;
      status_read(v, oe);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL mid_status got %h want 00", v); end
      repeat (10) @(negedge phi2);
      checks++;
      if (wr_q.size() !== 0 || n_reads !== 0) begin
         errors++; $display("FAIL mid_quiet got writes=%0d reads=%0d want 0 0", wr_q.size(), n_reads);
      end
   endtask

`ifdef FLASH_PROG_VERIFY_EN
   task automatic test_verify;
      logic [7:0] v; logic oe; int cyc;
      arm_model(1, 8'hFE);
      start_seq(8'h01, 19'h00400, 8'hFF);
      wait_idle(cyc);
      checks++;
      if (n_reads !== 4) begin errors++; $display("FAIL verify_reads got %0d want 4", n_reads); end
      status_read(v, oe);
      checks++;
      if (v !== 8'h06) begin errors++; $display("FAIL verify_status got %h want 06", v); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cmd_filter();
      test_program();
      test_erase();
      test_timeout();
      test_overrun();
      test_reset_mid();
`ifdef FLASH_PROG_VERIFY_EN
      test_verify();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
